// File: rtl/mod_logic_pipe_if.sv
// ============================================================================
// Module      : mod_logic_pipe_if
// Description : Handshake bundle for mod_logic_pipe. Signal names are written
//               from the logic unit's point of view: i_* flow into the unit,
//               o_* flow out of it.
//               Input side : i_in_valid / o_in_ready, i_op, i_acc, i_last,
//                            i_a, i_b, i_c
//               Output side: o_out_valid / i_out_ready, o_y, o_err,
//                            o_op_count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mod_logic_pipe_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic [2:0]           i_op;
  logic                 i_acc;
  logic                 i_last;
  logic [0:WIDTH-1]     i_a;
  logic [0:WIDTH-1]     i_b;
  logic [0:WIDTH-1]     i_c;
  logic                 o_out_valid;
  logic                 i_out_ready;
  logic [0:WIDTH-1]     o_y;
  logic                 o_err;
  logic [CNT_W-1:0]     o_op_count;

  // Logic unit side
  modport slave (
    input  i_in_valid, i_op, i_acc, i_last, i_a, i_b, i_c, i_out_ready,
    output o_in_ready, o_out_valid, o_y, o_err, o_op_count
  );

  // Producer/consumer side
  modport master (
    output i_in_valid, i_op, i_acc, i_last, i_a, i_b, i_c, i_out_ready,
    input  o_in_ready, o_out_valid, o_y, o_err, o_op_count
  );
endinterface

`default_nettype wire

// File: rtl/mod_logic_pipe.sv
// ============================================================================
// Module      : mod_logic_pipe
// Description : Registered bitwise logic unit for the SHA-256 datapath.
//               Computes one of eight bitwise functions (AND, OR, XOR, NOT,
//               CH, MAJ, XOR3, ANDN) of up to three operands and can fold a
//               multi-beat accumulate run into a single result.
//               Ports: clk, rst (async, active high), s_bus (slave modport of
//               mod_logic_pipe_if carrying both valid/ready handshakes,
//               operands, result, abort pulse and delivered-result count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_logic_pipe #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mod_logic_pipe_if.slave    s_bus
);

  localparam logic [2:0] c_OP_AND  = 3'd0;
  localparam logic [2:0] c_OP_OR   = 3'd1;
  localparam logic [2:0] c_OP_XOR  = 3'd2;
  localparam logic [2:0] c_OP_NOT  = 3'd3;
  localparam logic [2:0] c_OP_CH   = 3'd4;
  localparam logic [2:0] c_OP_MAJ  = 3'd5;
  localparam logic [2:0] c_OP_XOR3 = 3'd6;
  localparam logic [2:0] c_OP_ANDN = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t               r_state;
  logic [0:WIDTH-1]     r_acc;
  logic [0:WIDTH-1]     r_y;
  logic                 r_out_valid;
  logic                 r_err;
  logic [CNT_W-1:0]     r_op_count;

  logic                 w_in_ready;
  logic                 w_take;
  logic                 w_produce;
  logic                 w_out_hs;
  logic [0:WIDTH-1]     w_x;
  logic [0:WIDTH-1]     w_res;

  function automatic logic [0:WIDTH-1] f_logic(
    input logic [2:0]       op,
    input logic [0:WIDTH-1] x,
    input logic [0:WIDTH-1] y,
    input logic [0:WIDTH-1] z
  );
    logic [0:WIDTH-1] r;
    r = '0;
    case (op)
      c_OP_AND:  r = x & y;
      c_OP_OR:   r = x | y;
      c_OP_XOR:  r = x ^ y;
      c_OP_NOT:  r = ~x;
      c_OP_CH:   r = (x & y) ^ (~x & z);
      c_OP_MAJ:  r = (x & y) ^ (x & z) ^ (y & z);
      c_OP_XOR3: r = x ^ y ^ z;
      c_OP_ANDN: r = ~x & y;
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Ready only looks at the output register, so an accepted result can be
  // replaced in the same cycle the consumer takes it.
  assign w_in_ready = !r_out_valid || s_bus.i_out_ready;
  assign w_take     = s_bus.i_in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && s_bus.i_out_ready;

  // Any non-accumulate beat (including an aborting one) and any LAST beat
  // produces a result; LAST is only meaningful while ACC is set.
  assign w_produce  = w_take && (!s_bus.i_acc || s_bus.i_last);

  // Continuing run substitutes the accumulator for A; an aborting beat
  // (ACC=0 while in ACCUM) starts fresh from its own A.
  assign w_x   = (r_state == ST_ACCUM && s_bus.i_acc) ? r_acc : s_bus.i_a;
  assign w_res = f_logic(s_bus.i_op, w_x, s_bus.i_b, s_bus.i_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_err <= 1'b0;

      if (w_out_hs) begin
        r_op_count <= r_op_count + 1'b1;
      end

      // A newly loaded result wins over the consumer draining the old one.
      if (w_produce) begin
        r_y         <= w_res;
        r_out_valid <= 1'b1;
      end else if (s_bus.i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_take) begin
        case (r_state)
          ST_IDLE: begin
            if (s_bus.i_acc && !s_bus.i_last) begin
              r_acc   <= w_res;
              r_state <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            if (!s_bus.i_acc) begin
              r_acc   <= '0;
              r_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else if (s_bus.i_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_acc <= w_res;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign s_bus.o_in_ready  = w_in_ready;
  assign s_bus.o_out_valid = r_out_valid;
  assign s_bus.o_y         = r_y;
  assign s_bus.o_err       = r_err;
  assign s_bus.o_op_count  = r_op_count;

endmodule

`default_nettype wire

// File: doc/mod_logic_pipe.md
# mod_logic_pipe

Parametrised, registered bitwise logic unit for the SHA-256 datapath; the next generation of the fixed 32-bit AND block. It evaluates one of eight bitwise functions of up to three WIDTH-bit operands, including the SHA-256 Ch, Maj and three-way XOR. It can fold a multi-beat sequence into one result in accumulate mode. Input and output use valid/ready handshakes, so the block sits between the message-schedule/round-state registers and the round adder chain.

## Interface
- WIDTH, 32, operand and result width in bits
- CNT_W, 16, width of the completed-result counter
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  operand beat present
- IN_READY  output  1  block accepts a beat this cycle
- OP  input  3  function select, sampled with the beat
- ACC  input  1  beat belongs to an accumulate run
- LAST  input  1  final beat of an accumulate run (ignored when ACC=0)
- A, B, C  input  WIDTH each  operands (bit 0 = MSB, [0:WIDTH-1] ordering)
- OUT_VALID  output  1  Y holds a result
- OUT_READY  input  1  consumer takes Y this cycle
- Y  output  WIDTH  result
- ERR  output  1  one-cycle pulse: accumulate run aborted
- OP_COUNT  output  CNT_W  number of results delivered (output handshakes), wraps

## Operation
- Function f(OP,x,y,z), per bit: 0 AND x&y; 1 OR x|y; 2 XOR x^y; 3 NOT ~x; 4 CH (x&y)^(~x&z); 5 MAJ (x&y)^(x&z)^(y&z); 6 XOR3 x^y^z; 7 ANDN ~x&y. Unused operands are ignored.
- Beat accepted when IN_VALID && IN_READY.
- IN_READY = !OUT_VALID || OUT_READY. This is combinational and holds for every beat type.
- State machine with two states: IDLE and ACCUM. It holds an accumulator register ACC_R (WIDTH).
- IDLE, accepted beat, ACC=0: Y <= f(OP,A,B,C); OUT_VALID <= 1.
- IDLE, accepted beat, ACC=1, LAST=0: ACC_R <= f(OP,A,B,C); go to ACCUM; no output.
- IDLE, accepted beat, ACC=1, LAST=1: single-beat run, same as the ACC=0 case.
- ACCUM, accepted beat, ACC=1, LAST=0: ACC_R <= f(OP,ACC_R,B,C). A is ignored.
- ACCUM, accepted beat, ACC=1, LAST=1: Y <= f(OP,ACC_R,B,C); OUT_VALID <= 1; go to IDLE.
- ACCUM, accepted beat, ACC=0: the run is aborted and ACC_R is discarded. ERR pulses for one cycle. The beat is processed as in IDLE (Y <= f(OP,A,B,C)). Go to IDLE.
- OP is sampled per beat. It may differ between beats of one run.
- Output register: OUT_VALID clears on OUT_READY unless a new result loads in the same cycle. Y holds stable while OUT_VALID && !OUT_READY.
- OP_COUNT increments on each OUT_VALID && OUT_READY cycle. It wraps from 2^CNT_W-1 to 0.
- IN_VALID low: no state change. Accumulate runs may stall indefinitely.

## Timing
- Reset (async assert, state cleared immediately): IN_READY=1 (it is derived from OUT_VALID=0), OUT_VALID=0, Y=0, ERR=0, OP_COUNT=0, ACC_R=0, state IDLE.
- RST asserted mid-run: the run is lost and no ERR is generated. The pending Y is dropped.
- Latency: OUT_VALID rises one cycle after the accepting edge of a result-producing beat.
- Throughput is 1 beat/cycle with OUT_READY held high, including back-to-back results.
- With OUT_VALID=1 and OUT_READY=1, a new beat is accepted in the same cycle. The new Y replaces the old at that edge, OUT_VALID stays 1, and OP_COUNT increments once.
- ERR is asserted in the cycle after the aborting beat is accepted, for exactly one cycle.
- There is no combinational path from A/B/C/OP to Y. IN_READY depends only on OUT_VALID and OUT_READY.

## Test plan
- Reset, then OP=0 with A=FFFFFFFF and B=FFFFFFFF, then A=FFFFFFFF and B=00000000, OUT_READY=1 -> Y=FFFFFFFF then 00000000. Each Y appears one cycle after its beat. OP_COUNT=2.
- OP=4 (CH), A=F0F0F0F0, B=AAAAAAAA, C=55555555 -> Y=A5A5A5A5. OP=5 (MAJ), same operands -> Y=F0F0F0F0. OP=6 (XOR3), A=12345678, B=FFFFFFFF, C=0 -> Y=EDCBA987.
- Accumulate AND, 3 beats: beat 1 A=FFFF00FF, B=FFFFFFFF; beat 2 B=0FFFFFFF; beat 3 LAST=1, B=FFFFFFF0 -> exactly one result, Y=0FFF00F0. OUT_VALID stays low for beats 1–2.
- Backpressure: hold OUT_READY=0 with one result pending -> IN_READY=0, Y stable for 5 cycles, and a beat offered on IN_VALID is not taken. Raise OUT_READY -> the beat is accepted in the same cycle, and OP_COUNT increments by 1.
- Abort: ACC=1 beat (OP=1, A=1), then ACC=0 beat OP=0, A=FFFFFFFF, B=0000FFFF -> ERR pulses one cycle, Y=0000FFFF, state IDLE. A following ACC=1, LAST=1 beat computes from its own A.
- Assert RST mid-run and while a result is pending -> all outputs zero immediately, and no OUT_VALID after release. With CNT_W=2, 5 delivered results -> OP_COUNT=1.
